fft_input_loader: RTL

//   Upstream stage of the 32-point radix-2 FFT core. Accepts a stream of complex samples over a

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_input_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and address helpers for the 32-point radix-2 FFT core.
// Complex samples are packed {re, im}, each DATA_W bits of two's complement.
package fft_pkg;

    localparam int N_LOG2    = 5;
    localparam int DATA_W    = 32;
    localparam int SAMPLE_W  = 2 * DATA_W;
    localparam int FRAME_LEN = 1 << N_LOG2;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2
    } fft_state_e;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = a[N_LOG2-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Streams one frame of complex samples into the FFT bank at bit-reversed addresses, then
// kicks the core and waits for fft_done. Optional 1/N prescaling via `FFT_IN_PRESCALE_EN.
module fft_input_loader
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_last,
    output logic                mem_we,
    output logic [N_LOG2-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_din,
    output logic                mem_owner,
    output logic                start_fft,
    input  logic                fft_done,
    output logic                frame_err
);

    localparam logic [N_LOG2-1:0] CNT_MAX = '1;

    fft_state_e              state_q, state_d;
    logic [N_LOG2-1:0]       cnt_q, cnt_d;
    logic                    s_ready_q, s_ready_d;
    logic                    mem_we_q, mem_we_d;
    logic [N_LOG2-1:0]       mem_addr_q, mem_addr_d;
    logic [SAMPLE_W-1:0]     mem_din_q, mem_din_d;
    logic                    mem_owner_q, mem_owner_d;
    logic                    start_fft_q, start_fft_d;
    logic                    frame_err_q, frame_err_d;
    logic                    xfer;
    logic                    last_slot;

    function automatic logic [SAMPLE_W-1:0] prescale(input logic [SAMPLE_W-1:0] d);
`ifdef FFT_IN_PRESCALE_EN
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        re = d[SAMPLE_W-1:DATA_W];
        im = d[DATA_W-1:0];
        return {re >>> N_LOG2, im >>> N_LOG2};
`else
        return d;
`endif
    endfunction

    // s_ready_q is only ever 1 in LOAD, so xfer implies LOAD.
    assign xfer      = s_valid && s_ready_q;
    assign last_slot = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (xfer && last_slot) state_d = StStart;
            StStart: state_d = StRun;
            StRun:   if (fft_done) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        frame_err_d = frame_err_q;
        if (xfer) begin
            mem_we_d   = 1'b1;
            mem_addr_d = bitrev(cnt_q);
            mem_din_d  = prescale(s_data);
            if (last_slot) begin
                cnt_d = '0;
                if (!s_last) frame_err_d = 1'b1;
            end else if (s_last) begin
                // Short frame: keep the write but drop the partial frame.
                cnt_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        s_ready_d   = (state_d == StLoad);
        mem_owner_d = (state_d != StRun);
        start_fft_d = (state_q == StStart);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_owner_q <= 1'b1;
            start_fft_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_owner_q <= mem_owner_d;
            start_fft_q <= start_fft_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_owner = mem_owner_q;
    assign start_fft = start_fft_q;
    assign frame_err = frame_err_q;

endmodule
